// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU step/run clock-enable controller.
// State encoding matches the mode select so the FSM can load it directly.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {
    ST_HALT = MODE_HALT,
    ST_FREE = MODE_FREE,
    ST_SLOW = MODE_SLOW,
    ST_STEP = MODE_STEP
  } state_e;

  localparam int DB_CYCLES_DEF = 20;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board-side control bundle: slow clock, step button, mode in;
// CPU enable, enable count and state out.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             slow_clk;
  logic             btn;
  logic [1:0]       mode;
  logic             cpu_en;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       state;

  modport master (
    output slow_clk,
    output btn,
    output mode,
    input  cpu_en,
    input  tick_cnt,
    input  state
  );

  modport slave (
    input  slow_clk,
    input  btn,
    input  mode,
    output cpu_en,
    output tick_cnt,
    output state
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for a raw pushbutton.
// press_o is a one-cycle pulse registered alongside the rising stable level.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [15:0] LAST = 16'(DB_CYCLES - 2);

  logic        sync1_q;
  logic        sync2_q;
  logic        stable_q;
  logic        stable_d;
  logic        press_q;
  logic        press_d;
  logic [15:0] db_cnt_q;
  logic [15:0] db_cnt_d;

  // Accept the new level on the cycle the count would reach DB_CYCLES-1
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the slow divided clock and step button into a one-cycle
// CPU clock-enable, selected by halt/free/slow/step mode.
module cpu_step_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             slow_clk_i,
  input  logic             btn_i,
  input  logic [1:0]       mode_i,
  output logic             cpu_en_o,
  output logic [CNT_W-1:0] tick_cnt_o,
  output logic [1:0]       state_o
);

  logic             slow1_q;
  logic             slow2_q;
  logic             hist_q;
  logic             slow_rise;
  logic             btn_stable;
  logic             press;
  state_e           state_q;
  logic             cpu_en_q;
  logic             cpu_en_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk_i   (clk_i),
    .rst     (rst),
    .btn_i   (btn_i),
    .stable_o(btn_stable),
    .press_o (press)
  );

  // Slow clock is data here: sync, then rising-edge detect
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      slow1_q <= 1'b0;
      slow2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      slow1_q <= slow_clk_i;
      slow2_q <= slow1_q;
      hist_q  <= slow2_q;
    end
  end

  assign slow_rise = slow2_q & ~hist_q;

  always_comb begin
    cpu_en_d = 1'b0;
    unique case (state_q)
      ST_HALT: cpu_en_d = 1'b0;
      ST_FREE: cpu_en_d = 1'b1;
      ST_SLOW: cpu_en_d = slow_rise;
      ST_STEP: cpu_en_d = press & btn_stable;
    endcase
    cnt_d = cnt_q + CNT_W'(cpu_en_q);
  end

  // Events are judged against the state held before this edge
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HALT;
      cpu_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_e'(mode_i);
      cpu_en_q <= cpu_en_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_en_o   = cpu_en_q;
  assign tick_cnt_o = cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: vector table for mode latency,
// hand sequences for slow, step, wrap and reset corners.
module tb_cpu_step_ctrl;
  import cpu_clk_pkg::*;

  localparam int DB = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_step_ctrl_if #(.CNT_W(16)) bus ();
  cpu_step_ctrl_if #(.CNT_W(4))  bus4 ();

  cpu_step_ctrl #(.DB_CYCLES(DB), .CNT_W(16)) u_dut (
    .clk_i     (clk),
    .rst       (rst_n),
    .slow_clk_i(bus.slow_clk),
    .btn_i     (bus.btn),
    .mode_i    (bus.mode),
    .cpu_en_o  (bus.cpu_en),
    .tick_cnt_o(bus.tick_cnt),
    .state_o   (bus.state)
  );

  cpu_step_ctrl #(.DB_CYCLES(DB), .CNT_W(4)) u_dut4 (
    .clk_i     (clk),
    .rst       (rst_n),
    .slow_clk_i(bus4.slow_clk),
    .btn_i     (bus4.btn),
    .mode_i    (bus4.mode),
    .cpu_en_o  (bus4.cpu_en),
    .tick_cnt_o(bus4.tick_cnt),
    .state_o   (bus4.state)
  );

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [1:0] st;
  } vec_t;

  vec_t tv [10];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int first_pulse = -1;
  int last_pulse = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cpu_en === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
  endtask

  task automatic clr();
    pulses = 0;
    first_pulse = -1;
    last_pulse = -1;
  endtask

  initial begin
    int k;
    int bad;
    logic [15:0] base;
    logic [15:0] d;
    logic [3:0] prev4;
    logic saw_wrap;

    tv[0] = '{mode: MODE_FREE, en: 1'b0, st: MODE_FREE};
    tv[1] = '{mode: MODE_FREE, en: 1'b1, st: MODE_FREE};
    tv[2] = '{mode: MODE_HALT, en: 1'b1, st: MODE_HALT};
    tv[3] = '{mode: MODE_HALT, en: 1'b0, st: MODE_HALT};
    tv[4] = '{mode: MODE_SLOW, en: 1'b0, st: MODE_SLOW};
    tv[5] = '{mode: MODE_SLOW, en: 1'b0, st: MODE_SLOW};
    tv[6] = '{mode: MODE_STEP, en: 1'b0, st: MODE_STEP};
    tv[7] = '{mode: MODE_FREE, en: 1'b0, st: MODE_FREE};
    tv[8] = '{mode: MODE_SLOW, en: 1'b1, st: MODE_SLOW};
    tv[9] = '{mode: MODE_HALT, en: 1'b0, st: MODE_HALT};

    bus.slow_clk  = 1'b1;
    bus.btn       = 1'b1;
    bus.mode      = MODE_HALT;
    bus4.slow_clk = 1'b0;
    bus4.btn      = 1'b0;
    bus4.mode     = MODE_HALT;

    // Reset state and first cycles after release
    repeat (3) begin
      step();
      chk("rst_en", 32'(bus.cpu_en), 0);
      chk("rst_cnt", 32'(bus.tick_cnt), 0);
      chk("rst_state", 32'(bus.state), 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      step();
      chk("post_rst_en", 32'(bus.cpu_en), 0);
      chk("post_rst_cnt", 32'(bus.tick_cnt), 0);
      chk("post_rst_state", 32'(bus.state), 0);
    end
    bus.slow_clk = 1'b0;
    bus.btn = 1'b0;
    repeat (5) step();

    // Mode latency table
    base = bus.tick_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.mode = tv[i].mode;
      step();
      chk($sformatf("tv%0d_en", i), 32'(bus.cpu_en), 32'(tv[i].en));
      chk($sformatf("tv%0d_state", i), 32'(bus.state), 32'(tv[i].st));
    end
    d = bus.tick_cnt - base;
    chk("tv_cnt", 32'(d), 3);

    // SLOW: five slow periods of 40 cycles
    bus.mode = MODE_SLOW;
    repeat (3) step();
    clr();
    bad = 0;
    base = bus.tick_cnt;
    for (int c = 0; c < 200; c++) begin
      bus.slow_clk = ((c % 40) < 20);
      step();
      if (bus.cpu_en !== ((c >= 2) && ((c - 2) % 40 == 0))) bad++;
    end
    repeat (3) step();
    chk("slow_pulses", 32'(pulses), 5);
    chk("slow_pos_err", 32'(bad), 0);
    d = bus.tick_cnt - base;
    chk("slow_cnt", 32'(d), 5);

    // Slow rise discarded when mode leaves SLOW before it is judged
    clr();
    bus.slow_clk = 1'b1;
    step();
    bus.mode = MODE_HALT;
    repeat (4) step();
    chk("slow_discard", 32'(pulses), 0);
    bus.slow_clk = 1'b0;
    bus.mode = MODE_SLOW;
    repeat (3) step();
    clr();
    bus.slow_clk = 1'b1;
    step();
    step();
    bus.mode = MODE_HALT;
    step();
    chk("slow_same_edge_en", 32'(bus.cpu_en), 1);
    repeat (3) step();
    chk("slow_same_edge_pulses", 32'(pulses), 1);
    bus.slow_clk = 1'b0;

    // STEP: bounces, then a held press, then release
    bus.mode = MODE_STEP;
    repeat (3) step();
    clr();
    repeat (3) begin
      bus.btn = 1'b1;
      repeat (3) step();
      bus.btn = 1'b0;
      repeat (3) step();
    end
    chk("bounce_pulses", 32'(pulses), 0);
    k = cyc + 1;
    bus.btn = 1'b1;
    repeat (30) step();
    bus.btn = 1'b0;
    repeat (40) step();
    chk("step_pulses", 32'(pulses), 1);
    chk("step_latency", 32'(first_pulse - k), DB + 1);

    // FREE for 10 cycles then HALT
    bus.mode = MODE_HALT;
    repeat (2) step();
    base = bus.tick_cnt;
    clr();
    k = cyc + 1;
    bus.mode = MODE_FREE;
    repeat (10) step();
    bus.mode = MODE_HALT;
    repeat (5) step();
    chk("free_pulses", 32'(pulses), 10);
    chk("free_first", 32'(first_pulse - k), 1);
    chk("free_run_len", 32'(last_pulse - first_pulse + 1), 10);
    d = bus.tick_cnt - base;
    chk("free_cnt", 32'(d), 10);

    // 4-bit counter wraps after 16 enables
    chk("w4_start", 32'(bus4.tick_cnt), 0);
    saw_wrap = 1'b0;
    prev4 = bus4.tick_cnt;
    for (int c = 0; c < 20; c++) begin
      bus4.mode = (c < 17) ? MODE_FREE : MODE_HALT;
      step();
      if (prev4 == 4'd15 && bus4.tick_cnt == 4'd0) saw_wrap = 1'b1;
      prev4 = bus4.tick_cnt;
    end
    chk("w4_wrap_seen", 32'(saw_wrap), 1);
    chk("w4_cnt", 32'(bus4.tick_cnt), 1);

    // Button held while entering STEP gives no pulse
    bus.btn = 1'b1;
    repeat (30) step();
    clr();
    bus.mode = MODE_STEP;
    repeat (10) step();
    chk("held_entry", 32'(pulses), 0);
    bus.btn = 1'b0;
    repeat (30) step();
    chk("held_release", 32'(pulses), 0);
    k = cyc + 1;
    bus.btn = 1'b1;
    repeat (30) step();
    chk("repress_pulses", 32'(pulses), 1);
    chk("repress_latency", 32'(first_pulse - k), DB + 1);

    // Reset mid-debounce restarts the count from zero
    bus.btn = 1'b0;
    repeat (30) step();
    clr();
    bus.btn = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.state), 0);
    chk("midrst_en", 32'(bus.cpu_en), 0);
    chk("midrst_cnt", 32'(bus.tick_cnt), 0);
    repeat (2) step();
    rst_n = 1'b1;
    k = cyc + 1;
    repeat (30) step();
    chk("midrst_pulses", 32'(pulses), 1);
    chk("midrst_latency", 32'(first_pulse - k), DB + 1);
    chk("midrst_state_after", 32'(bus.state), 32'(MODE_STEP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
